// File: rtl/display_scan_pkg.sv
// Shared parameters and leading-zero helper for display_scan.
// Latency: n/a (package).
// Backpressure: n/a.
package display_scan_pkg;

`include "display_defs.vh"

    localparam int DEF_NUM_DIGITS  = `DISPLAY_NUM_DIGITS;
    localparam int DEF_REFRESH_DIV = `DISPLAY_REFRESH_DIV;
    localparam int DEF_DEAD_CYC    = `DISPLAY_DEAD_CYC;
    localparam int MAX_DIGITS      = 8;

    // Returns a mask of digits that are leading-zero blanked. Walks from the
    // most significant populated digit downwards; a digit is blanked while it
    // and every digit above it are zero. Digit 0 is never blanked.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] val,
        input logic                    lz,
        input int                      n
    );
        logic                  zero_above;
        logic [MAX_DIGITS-1:0] m;
        m          = '0;
        zero_above = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < n) begin
                zero_above = zero_above & (val[4*i +: 4] == 4'h0);
                m[i]       = lz & zero_above;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/display_defs.vh
// Shared defaults for the display scan block.
// Latency: n/a (constants only).
// Backpressure: n/a.
`ifndef DISPLAY_DEFS_VH
`define DISPLAY_DEFS_VH

`define DISPLAY_NUM_DIGITS  8
`define DISPLAY_REFRESH_DIV 100000
`define DISPLAY_DEAD_CYC    4

// Inactive levels for the active-low anode and decimal-point pins.
`define DISPLAY_AN_OFF      '1
`define DISPLAY_DP_OFF      1'b1

`endif

// File: rtl/display_scan_refresh_divider.sv
// Slot counter: counts 0..REFRESH_DIV-1 and flags the cycle before it wraps.
// Latency: cnt registered; cnt_next/slot_wrap combinational from cnt.
// Backpressure: none, free-running.
// Ports: clk, reset_n (async active-low); cnt (current), cnt_next (value after
// the coming edge), slot_wrap (high when the coming edge wraps cnt to 0).
module refresh_divider
    import display_scan_pkg::*;
#(
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int CW          = $clog2(REFRESH_DIV)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_next,
    output logic          slot_wrap
);

    always_comb begin
        slot_wrap = (cnt == CW'(REFRESH_DIV - 1));
        cnt_next  = slot_wrap ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/display_scan.sv
// Scan controller for a common-anode multi-digit 7-segment display.
// Latency: all outputs registered, computed from post-edge counter/digit/snapshot.
// Backpressure: none; inputs are sampled only at frame start (and once after reset).
// Ports: clk, reset_n; value/digit_en/dp_in/blank_lz (frame inputs);
// state (nibble to hex_to_7seg), an (active-low anodes), dp (active-low),
// digit_sel (current digit), frame_tick (pulse when digit_sel wraps to 0).
module display_scan
    import display_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int DEAD_CYC    = DEF_DEAD_CYC
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          blank_lz,
    output logic [3:0]                    state,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic                          frame_tick
);

`include "display_defs.vh"

    localparam int SW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = `DISPLAY_AN_OFF;
    localparam logic                  DP_OFF = `DISPLAY_DP_OFF;

    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_next;
    logic                    slot_wrap;
    logic                    frame_wrap;
    logic                    load_pending;
    logic                    load;
    logic [SW-1:0]           sel_next;

    logic [4*NUM_DIGITS-1:0] snap_val,  snap_val_n;
    logic [NUM_DIGITS-1:0]   snap_en,   snap_en_n;
    logic [NUM_DIGITS-1:0]   snap_dp,   snap_dp_n;
    logic                    snap_lz,   snap_lz_n;

    logic [MAX_DIGITS-1:0]   blank_all;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [3:0]              state_next;
    logic                    dp_next;

    refresh_divider #(
        .REFRESH_DIV (REFRESH_DIV),
        .CW          (CW)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .cnt       (cnt),
        .cnt_next  (cnt_next),
        .slot_wrap (slot_wrap)
    );

    // Everything below looks ahead to the post-edge counter, digit and
    // snapshot so the registered outputs line up with digit_sel exactly.
    always_comb begin
        frame_wrap = slot_wrap && (digit_sel == SW'(NUM_DIGITS - 1));
        sel_next   = digit_sel;
        if (slot_wrap) begin
            sel_next = frame_wrap ? '0 : digit_sel + 1'b1;
        end

        // Snapshot only at frame boundaries (or the first edge after reset)
        // so a changing value never tears across one frame.
        load       = frame_wrap | load_pending;
        snap_val_n = load ? value    : snap_val;
        snap_en_n  = load ? digit_en : snap_en;
        snap_dp_n  = load ? dp_in    : snap_dp;
        snap_lz_n  = load ? blank_lz : snap_lz;

        blank_all  = lz_mask(32'(snap_val_n), snap_lz_n, NUM_DIGITS);
        lit        = snap_en_n[sel_next] & ~blank_all[sel_next]
                     & (cnt_next >= CW'(DEAD_CYC));

        an_next = AN_OFF;
        if (lit) begin
            an_next[sel_next] = 1'b0;
        end
        state_next = snap_val_n[{sel_next, 2'b00} +: 4];
        dp_next    = ~(snap_dp_n[sel_next] & lit);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_pending <= 1'b1;
            digit_sel    <= '0;
            frame_tick   <= 1'b0;
            snap_val     <= '0;
            snap_en      <= '0;
            snap_dp      <= '0;
            snap_lz      <= 1'b0;
            an           <= AN_OFF;
            state        <= 4'h0;
            dp           <= DP_OFF;
        end else begin
            load_pending <= 1'b0;
            digit_sel    <= sel_next;
            frame_tick   <= frame_wrap;
            snap_val     <= snap_val_n;
            snap_en      <= snap_en_n;
            snap_dp      <= snap_dp_n;
            snap_lz      <= snap_lz_n;
            an           <= an_next;
            state        <= state_next;
            dp           <= dp_next;
        end
    end

endmodule
